// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: opcodes, FSM state encodings and button indices.
package alu_pkg;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;

  localparam int BTN_ENTER = 0;
  localparam int BTN_BACK  = 1;
  localparam int BTN_CLEAR = 2;

  function automatic logic op_valid(input logic [5:0] op);
    case (op)
      ADD, SUB, AND, OR, XOR, NOR, SRA, SRL: op_valid = 1'b1;
      default:                               op_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational signed ALU; unknown opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int N_BITS_DATA = 8,
  parameter int N_BITS_OP   = 6
) (
  input  logic signed [N_BITS_DATA-1:0] i_a,
  input  logic signed [N_BITS_DATA-1:0] i_b,
  input  logic        [N_BITS_OP-1:0]   i_op,
  output logic signed [N_BITS_DATA-1:0] o_res
);

  always_comb begin
    o_res = '0;
    case (6'(i_op))
      ADD: o_res = i_a + i_b;
      SUB: o_res = i_a - i_b;
      AND: o_res = i_a & i_b;
      OR:  o_res = i_a | i_b;
      XOR: o_res = i_a ^ i_b;
      NOR: o_res = ~(i_a | i_b);
      SRA: o_res = i_a >>> $unsigned(i_b);
      SRL: o_res = $signed($unsigned(i_a) >> $unsigned(i_b));
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Per-button 2-FF synchroniser, optional debounce (DEBOUNCE_EN) and rising-edge pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic prev_d, pulse_d;
  logic lvl;

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Level only follows the input after DEBOUNCE_CYCLES samples that disagree with it in a row.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d = '0;
      db_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign lvl = db_q;
`else
  assign lvl = sync2_q;
`endif

  always_comb begin
    prev_d  = lvl;
    pulse_d = lvl & ~prev_q;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_seq_controller.sv
// Sequenced operand-entry front end for alu: enter/back/clear buttons drive A -> B -> op -> result.
// Build option: DEBOUNCE_EN adds per-button debounce inside button_conditioner.
module alu_seq_controller
  import alu_pkg::*;
#(
  parameter int N_BITS_DATA     = 8,
  parameter int N_BITS_OP       = 6,
  parameter int N_PULSADORES    = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic signed [N_BITS_DATA-1:0] i_switches,
  input  logic        [N_PULSADORES-1:0] i_pulsadores,
  output logic signed [N_BITS_DATA-1:0] o_resultado,
  output logic                          o_valid,
  output logic                          o_zero,
  output logic                          o_error,
  output logic        [2:0]             o_state
);

  logic [N_PULSADORES-1:0] pulse;

  for (genvar i = 0; i < N_PULSADORES; i++) begin : g_btn
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_btn   (i_pulsadores[i]),
      .o_pulse (pulse[i])
    );
  end

  logic [2:0]                    state_q, state_d;
  logic signed [N_BITS_DATA-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
  logic [N_BITS_OP-1:0]          op_q, op_d;
  logic                          valid_q, valid_d, zero_q, zero_d, err_q, err_d;

  alu #(.N_BITS_DATA(N_BITS_DATA), .N_BITS_OP(N_BITS_OP)) u_alu (
    .i_a   (a_q),
    .i_b   (b_q),
    .i_op  (op_q),
    .o_res (alu_res)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    err_d   = err_q;
    // S_EXEC ignores buttons entirely; otherwise clear > back > enter.
    if (state_q == S_EXEC) begin
      res_d   = alu_res;
      zero_d  = (alu_res == '0);
      err_d   = !op_valid(6'(op_q));
      valid_d = 1'b1;
      state_d = S_RES;
    end else if (pulse[BTN_CLEAR]) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (pulse[BTN_BACK]) begin
      case (state_q)
        S_B:     state_d = S_A;
        S_OP:    state_d = S_B;
        S_RES: begin
          state_d = S_OP;
          valid_d = 1'b0;
        end
        default: state_d = state_q;
      endcase
    end else if (pulse[BTN_ENTER]) begin
      case (state_q)
        S_A: begin
          a_d     = i_switches;
          state_d = S_B;
        end
        S_B: begin
          b_d     = i_switches;
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = i_switches[N_BITS_OP-1:0];
          state_d = S_EXEC;
        end
        S_RES: begin
          valid_d = 1'b0;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign o_resultado = res_q;
  assign o_valid     = valid_q;
  assign o_zero      = zero_q;
  assign o_error     = err_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_alu_seq_controller.sv
// Directed bench for alu_seq_controller; expected values hand-computed.
module tb_alu_seq_controller;

`ifdef DEBOUNCE_EN
  localparam int LAT  = 7;
  localparam int HOLD = 12;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 4;
`endif

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b0;
  logic signed [7:0] i_switches = '0;
  logic [2:0]        i_pulsadores = '0;
  logic signed [7:0] o_resultado;
  logic              o_valid, o_zero, o_error;
  logic [2:0]        o_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clock = ~i_clock;

  alu_seq_controller #(
    .N_BITS_DATA(8), .N_BITS_OP(6), .N_PULSADORES(3), .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_switches   (i_switches),
    .i_pulsadores (i_pulsadores),
    .o_resultado  (o_resultado),
    .o_valid      (o_valid),
    .o_zero       (o_zero),
    .o_error      (o_error),
    .o_state      (o_state)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic press(input logic [2:0] m);
    i_pulsadores = m;
    cyc(HOLD);
    i_pulsadores = '0;
    cyc(HOLD);
  endtask

  task automatic enter_val(input logic [7:0] v);
    i_switches = v;
    press(3'b001);
  endtask

  task automatic run3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    enter_val(a);
    enter_val(b);
    enter_val(op);
  endtask

  initial begin
    cyc(3);
    chk("rst_state", 8'(o_state), 8'd0);
    chk("rst_res",   o_resultado, 8'h00);
    chk("rst_valid", 8'(o_valid), 8'd0);
    chk("rst_zero",  8'(o_zero),  8'd0);
    chk("rst_err",   8'(o_error), 8'd0);
    i_reset = 1'b1;
    cyc(2);

    // 5 + 3 with op-capture latency measured cycle by cycle
    enter_val(8'd5);
    chk("a_state", 8'(o_state), 8'd1);
    enter_val(8'd3);
    chk("b_state", 8'(o_state), 8'd2);
    i_switches   = 8'h20;
    i_pulsadores = 3'b001;
    cyc(LAT);
    chk("lat_pre",   8'(o_state), 8'd2);
    cyc(1);
    chk("lat_exec",  8'(o_state), 8'd3);
    chk("lat_v0",    8'(o_valid), 8'd0);
    cyc(1);
    chk("lat_res",   8'(o_state), 8'd4);
    chk("lat_v1",    8'(o_valid), 8'd1);
    chk("add_res",   o_resultado, 8'h08);
    chk("add_zero",  8'(o_zero),  8'd0);
    chk("add_err",   8'(o_error), 8'd0);
    i_pulsadores = '0;
    cyc(HOLD);

    press(3'b100);
    chk("clr_state", 8'(o_state), 8'd0);
    chk("clr_valid", 8'(o_valid), 8'd0);
    chk("clr_keep",  o_resultado, 8'h08);
    press(3'b010);
    chk("backA",     8'(o_state), 8'd0);

    run3(8'h7F, 8'h01, 8'h20);
    chk("wrap_res",  o_resultado, 8'h80);
    chk("wrap_st",   8'(o_state), 8'd4);
    enter_val(8'h00);
    chk("resA_st",   8'(o_state), 8'd0);
    chk("resA_v",    8'(o_valid), 8'd0);
    run3(8'd5, 8'd5, 8'h22);
    chk("sub_res",   o_resultado, 8'h00);
    chk("sub_zero",  8'(o_zero),  8'd1);
    chk("sub_v",     8'(o_valid), 8'd1);
    enter_val(8'h00);

    // invalid opcode, then valid re-execution clears error
    run3(8'd1, 8'd2, 8'h3F);
    chk("inv_err",   8'(o_error), 8'd1);
    chk("inv_v",     8'(o_valid), 8'd1);
    chk("inv_res",   o_resultado, 8'h00);
    press(3'b010);
    chk("back_st",   8'(o_state), 8'd2);
    chk("back_v",    8'(o_valid), 8'd0);
    chk("back_err",  8'(o_error), 8'd1);
    enter_val(8'h20);
    chk("reex_res",  o_resultado, 8'h03);
    chk("reex_err",  8'(o_error), 8'd0);
    enter_val(8'h00);
    run3(8'd1, 8'd2, 8'h3F);
    chk("inv2_err",  8'(o_error), 8'd1);
    press(3'b100);
    chk("clr2_err",  8'(o_error), 8'd0);
    chk("clr2_v",    8'(o_valid), 8'd0);
    chk("clr2_st",   8'(o_state), 8'd0);

    run3(8'h80, 8'h01, 8'h03);
    chk("sra_res",   o_resultado, 8'hC0);
    press(3'b010);
    enter_val(8'h02);
    chk("srl_res",   o_resultado, 8'h40);
    enter_val(8'h00);

    // simultaneous buttons
    enter_val(8'd10);
    enter_val(8'd3);
    i_switches = 8'h20;
    press(3'b011);
    chk("bk_en_st",  8'(o_state), 8'd1);
    press(3'b101);
    chk("cl_en_st",  8'(o_state), 8'd0);
    run3(8'd10, 8'd3, 8'h22);
    chk("sub7_res",  o_resultado, 8'h07);
    press(3'b010);
    chk("rop_st",    8'(o_state), 8'd2);
    enter_val(8'h20);
    chk("add13_res", o_resultado, 8'h0D);
    chk("add13_st",  8'(o_state), 8'd4);
    enter_val(8'h00);

    // long hold and mid-sequence reset
    i_switches   = 8'd9;
    i_pulsadores = 3'b001;
    cyc(50);
    i_pulsadores = '0;
    cyc(HOLD);
    chk("hold_st",   8'(o_state), 8'd1);
    enter_val(8'd4);
    chk("preR_st",   8'(o_state), 8'd2);
    i_reset = 1'b0;
    cyc(1);
    chk("mrst_st",   8'(o_state), 8'd0);
    chk("mrst_res",  o_resultado, 8'h00);
    chk("mrst_v",    8'(o_valid), 8'd0);
    chk("mrst_err",  8'(o_error), 8'd0);
    i_reset = 1'b1;
    cyc(2);

`ifdef DEBOUNCE_EN
    i_pulsadores = 3'b001;
    cyc(3);
    i_pulsadores = '0;
    cyc(15);
    chk("glitch_st", 8'(o_state), 8'd0);
    i_pulsadores = 3'b001;
    cyc(7);
    chk("db_pre",    8'(o_state), 8'd0);
    cyc(1);
    chk("db_post",   8'(o_state), 8'd1);
    i_pulsadores = '0;
    cyc(15);
    chk("db_one",    8'(o_state), 8'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
